// File: rtl/washer_plant_model.sv
// rtl/washer_plant_model.sv - behavioural washer plant: water level, detergent/wash/spin timers, door FSM
// Optional sticky fault detection is enabled by defining WASHER_PLANT_FAULT_EN.
module washer_plant_model #(
   parameter int FILL_CYCLES = 8,
   parameter int DET_CYCLES  = 3,
   parameter int WASH_CYCLES = 10,
   parameter int SPIN_CYCLES = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fillvalve_on,
   input  logic       drainvalve_on,
   input  logic       motor_on,
   input  logic       soap_wash,
   input  logic       water_wash,
   input  logic       doorlock,
   input  logic       door_cmd,
   output logic       filled,
   output logic       drained,
   output logic       detergent,
   output logic       cycletime_out,
   output logic       spintime_out,
   output logic       doorclose,
   output logic [7:0] water_level,
   output logic       fault
);

   localparam logic [7:0] FILL_MAX = 8'(FILL_CYCLES);
   localparam logic [7:0] DET_MAX  = 8'(DET_CYCLES);
   localparam logic [7:0] WASH_MAX = 8'(WASH_CYCLES);
   localparam logic [7:0] SPIN_MAX = 8'(SPIN_CYCLES);

   typedef enum logic [1:0] {
      DOOR_OPEN   = 2'd0,
      DOOR_CLOSED = 2'd1,
      DOOR_LOCKED = 2'd2
   } door_t;

   logic [7:0] level;
   logic [7:0] det_cnt;
   logic [7:0] wash_cnt;
   logic [7:0] spin_cnt;
   door_t      door_state;
   logic       doorclose_r;

   // Opposing valves cancel; flow saturates at the empty and full marks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level <= 8'd0;
      end else if (fillvalve_on && !drainvalve_on && level < FILL_MAX) begin
         level <= level + 8'd1;
      end else if (drainvalve_on && !fillvalve_on && level != 8'd0) begin
         level <= level - 8'd1;
      end
   end

   assign water_level = level;
   assign filled      = (level == FILL_MAX);
   assign drained     = (level == 8'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         det_cnt <= 8'd0;
      end else if (!soap_wash) begin
         det_cnt <= 8'd0;
      end else if (!water_wash && filled && det_cnt < DET_MAX) begin
         det_cnt <= det_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wash_cnt <= 8'd0;
      end else if (!motor_on) begin
         wash_cnt <= 8'd0;
      end else if (!drainvalve_on && filled && wash_cnt < WASH_MAX) begin
         wash_cnt <= wash_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spin_cnt <= 8'd0;
      end else if (!drainvalve_on) begin
         spin_cnt <= 8'd0;
      end else if (water_wash && drained && spin_cnt < SPIN_MAX) begin
         spin_cnt <= spin_cnt + 8'd1;
      end
   end

   assign detergent     = (det_cnt == DET_MAX);
   assign cycletime_out = (wash_cnt == WASH_MAX);
   assign spintime_out  = (spin_cnt == SPIN_MAX);

   // A closed door that is asked to open does so before it can be locked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         door_state  <= DOOR_OPEN;
         doorclose_r <= 1'b0;
      end else begin
         case (door_state)
            DOOR_OPEN: begin
               if (door_cmd) begin
                  door_state  <= DOOR_CLOSED;
                  doorclose_r <= 1'b1;
               end
            end
            DOOR_CLOSED: begin
               if (!door_cmd) begin
                  door_state  <= DOOR_OPEN;
                  doorclose_r <= 1'b0;
               end else if (doorlock) begin
                  door_state  <= DOOR_LOCKED;
                  doorclose_r <= 1'b1;
               end
            end
            DOOR_LOCKED: begin
               if (!doorlock) begin
                  door_state <= DOOR_CLOSED;
               end
               doorclose_r <= 1'b1;
            end
            default: begin
               door_state  <= DOOR_OPEN;
               doorclose_r <= 1'b0;
            end
         endcase
      end
   end

   assign doorclose = doorclose_r;

`ifdef WASHER_PLANT_FAULT_EN
   logic fault_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault_r <= 1'b0;
      end else if ((fillvalve_on && drainvalve_on) ||
                   (door_state == DOOR_LOCKED && !door_cmd)) begin
         fault_r <= 1'b1;
      end
   end

   assign fault = fault_r;
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_washer_plant_model.sv
// tb/tb_washer_plant_model.sv - scoreboard bench for washer_plant_model
// Honours WASHER_PLANT_FAULT_EN when the design is built with it.
module tb_washer_plant_model;

   localparam int FILL = 8;
   localparam int DETC = 3;
   localparam int WASH = 10;
   localparam int SPIN = 5;

   localparam int F = 64, D = 32, M = 16, S = 8, W = 4, L = 2, C = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fillvalve_on = 1'b0, drainvalve_on = 1'b0, motor_on = 1'b0;
   logic       soap_wash = 1'b0, water_wash = 1'b0, doorlock = 1'b0, door_cmd = 1'b0;
   logic       filled, drained, detergent, cycletime_out, spintime_out, doorclose, fault;
   logic [7:0] water_level;

   washer_plant_model #(
      .FILL_CYCLES(FILL), .DET_CYCLES(DETC), .WASH_CYCLES(WASH), .SPIN_CYCLES(SPIN)
   ) dut (
      .clk(clk), .rst(rst),
      .fillvalve_on(fillvalve_on), .drainvalve_on(drainvalve_on), .motor_on(motor_on),
      .soap_wash(soap_wash), .water_wash(water_wash), .doorlock(doorlock), .door_cmd(door_cmd),
      .filled(filled), .drained(drained), .detergent(detergent),
      .cycletime_out(cycletime_out), .spintime_out(spintime_out),
      .doorclose(doorclose), .water_level(water_level), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lvl; int det; int wsh; int spn; int door; int flt;
   } exp_t;

   exp_t expq[$];
   int n_assert = 0;
   int n_fail   = 0;

   // Reference plant: door 0=open, 1=closed, 2=locked.
   int m_lvl = 0, m_det = 0, m_wsh = 0, m_spn = 0, m_door = 0, m_flt = 0;

   function automatic void chk(string name, int act, int expv);
      n_assert++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endfunction

   function automatic void model_reset();
      m_lvl = 0; m_det = 0; m_wsh = 0; m_spn = 0; m_door = 0; m_flt = 0;
   endfunction

   function automatic void model_step(input logic [6:0] v);
      bit f = v[6], d = v[5], m = v[4], s = v[3], w = v[2], l = v[1], c = v[0];
      bit full  = (m_lvl == FILL);
      bit empty = (m_lvl == 0);
`ifdef WASHER_PLANT_FAULT_EN
      if ((f && d) || (m_door == 2 && !c)) m_flt = 1;
`endif
      if (f && !d)      m_lvl = (m_lvl + 1 > FILL) ? FILL : m_lvl + 1;
      else if (d && !f) m_lvl = (m_lvl - 1 < 0) ? 0 : m_lvl - 1;
      if (!s)                 m_det = 0;
      else if (!w && full)    m_det = (m_det + 1 > DETC) ? DETC : m_det + 1;
      if (!m)                 m_wsh = 0;
      else if (!d && full)    m_wsh = (m_wsh + 1 > WASH) ? WASH : m_wsh + 1;
      if (!d)                 m_spn = 0;
      else if (w && empty)    m_spn = (m_spn + 1 > SPIN) ? SPIN : m_spn + 1;
      if (m_door == 0)        m_door = c ? 1 : 0;
      else if (m_door == 1)   m_door = !c ? 0 : (l ? 2 : 1);
      else                    m_door = l ? 2 : 1;
   endfunction

   function automatic exp_t snap();
      exp_t e;
      e.lvl = m_lvl; e.det = m_det; e.wsh = m_wsh; e.spn = m_spn; e.door = m_door; e.flt = m_flt;
      return e;
   endfunction

   task automatic check_reset_outputs();
      chk("rst_level", int'(water_level), 0);
      chk("rst_drained", int'(drained), 1);
      chk("rst_filled", int'(filled), 0);
      chk("rst_detergent", int'(detergent), 0);
      chk("rst_cycletime", int'(cycletime_out), 0);
      chk("rst_spintime", int'(spintime_out), 0);
      chk("rst_doorclose", int'(doorclose), 0);
      chk("rst_fault", int'(fault), 0);
   endtask

   // One clock of stimulus; optional asynchronous reset pulse inside the low phase.
   task automatic step(input int vi, input bit pulse = 1'b0);
      logic [6:0] v = 7'(vi);
      @(negedge clk);
      if (pulse) begin
         #2 rst = 1'b1;
         #1 check_reset_outputs();
         model_reset();
         #1 rst = 1'b0;
      end
      {fillvalve_on, drainvalve_on, motor_on, soap_wash, water_wash, doorlock, door_cmd} = v;
      model_step(v);
      expq.push_back(snap());
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("water_level", int'(water_level), e.lvl);
            chk("filled", int'(filled), int'(e.lvl == FILL));
            chk("drained", int'(drained), int'(e.lvl == 0));
            chk("detergent", int'(detergent), int'(e.det == DETC));
            chk("cycletime_out", int'(cycletime_out), int'(e.wsh == WASH));
            chk("spintime_out", int'(spintime_out), int'(e.spn == SPIN));
            chk("doorclose", int'(doorclose), int'(e.door != 0));
            chk("fault", int'(fault), e.flt);
         end
      end
   end

   initial begin : stimulus
      int p[7];
      int v;
      #1 check_reset_outputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();

      repeat (9) step(F);                   // fill to full, then one saturating clock
      repeat (3) step(S);                   // detergent dispensed
      step(0);                              // soap off clears it
      repeat (10) step(M);                  // wash timer expires
      repeat (8) step(M | D);               // drain with motor held
      step(D);                              // motor drops
      repeat (6) step(D | W);               // spin timer expires at empty
      step(0);
      step(C); step(C | L); step(L); step(L); // lock, then request open while locked
      step(0); step(0);
      step(F, 1'b1);
      repeat (3) step(F);                   // level 4
      repeat (2) step(F | D);               // both valves: hold
      repeat (2) step(F);
      step(F, 1'b1);                        // reset mid-fill
      step(F);

      for (int blk = 0; blk < 80; blk++) begin
         case ($urandom_range(0, 4))
            0:       p = '{85, 5, 10, 10, 10, 40, 70};
            1:       p = '{5, 85, 10, 5, 60, 40, 70};
            2:       p = '{30, 3, 80, 80, 15, 60, 90};
            3:       p = '{3, 90, 5, 5, 90, 20, 50};
            default: p = '{50, 50, 50, 50, 50, 50, 50};
         endcase
         for (int k = 0; k < 20; k++) begin
            v = 0;
            for (int b = 0; b < 7; b++)
               if ($urandom_range(0, 99) < p[b]) v |= (64 >> b);
            step(v, $urandom_range(0, 299) == 0);
         end
      end

      repeat (3) @(negedge clk);
      chk("queue_empty", expq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
